// File: rtl/horner_pkg.sv
// horner_pkg: shared types and defaults for the Horner polynomial evaluator.
//   state_t   - FSM state encoding used by horner_eval_engine
//   DEF_WIDTH - default data width (x, coefficients, accumulator, result)
//   DEF_DEG_W - default width of degree / coefficient address
//   MAX_DEG   - largest degree representable with a given degree width
// Build option: HORNER_SAT_EN (consumed by horner_mac) selects saturating
// accumulation instead of modular wrap.
package horner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEG_W = 6;

  function automatic int MAX_DEG(input int deg_w);
    return (1 << deg_w) - 1;
  endfunction

endpackage

// File: rtl/horner_mac.sv
// horner_mac: one combinational Horner step, acc_next = floor(acc*x / 2**WIDTH) + coef.
// x is an unsigned Q0.WIDTH fraction, so keeping the upper half of the
// product is the fixed-point multiply.
// Ports:
//   acc      in  WIDTH  current accumulator
//   x        in  WIDTH  fractional operand
//   coef     in  WIDTH  coefficient being folded in
//   acc_next out WIDTH  next accumulator value
//   carry    out 1      sum exceeded WIDTH bits (overflow for this step)
// Build option: HORNER_SAT_EN defined clamps acc_next to all ones on carry;
// otherwise the sum wraps modulo 2**WIDTH.
module horner_mac #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] coef,
  output logic [WIDTH-1:0] acc_next,
  output logic             carry
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;

  assign prod  = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x};
  // Truncate (floor) the fractional half, then add with one guard bit.
  assign sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, coef};
  assign carry = sum[WIDTH];

`ifdef HORNER_SAT_EN
  assign acc_next = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign acc_next = sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/horner_eval_engine.sv
// horner_eval_engine: evaluates y = c[d]*x^d + ... + c[0] by Horner's rule,
// fetching one coefficient per cycle from an external 1-cycle-latency store.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous active-high reset
//   start     in  1      request evaluation (sampled in IDLE/HALT only)
//   fraction  in  WIDTH  x operand (Q0.WIDTH), latched on accepted start
//   degree    in  DEG_W  polynomial degree, latched on accepted start
//   coef_addr out DEG_W  coefficient index requested from the store
//   coef_in   in  WIDTH  store data, valid one cycle after coef_addr
//   result    out WIDTH  accumulator; final when we=1, held afterwards
//   we        out 1      one-cycle pulse marking the final result
//   halt      out 1      evaluation complete, waiting for start
//   busy      out 1      high during LOAD and RUN
//   ovf       out 1      sticky overflow of the current evaluation
// Build option: HORNER_SAT_EN (see horner_mac) selects saturation.
// Timing: accept edge ends cycle 0, LOAD is cycle 1, RUN cycles 2..d+2,
// WRITE (we) cycle d+3, HALT from cycle d+4. All outputs are registered.
module horner_eval_engine
  import horner_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEG_W = DEF_DEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] fraction,
  input  logic [DEG_W-1:0] degree,
  output logic [DEG_W-1:0] coef_addr,
  input  logic [WIDTH-1:0] coef_in,
  output logic [WIDTH-1:0] result,
  output logic             we,
  output logic             halt,
  output logic             busy,
  output logic             ovf
);

  state_t           state_reg, state_next;
  logic             accept;

  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [DEG_W-1:0] d_reg;
  logic [DEG_W-1:0] remaining_reg;
  logic [DEG_W-1:0] addr_reg;
  logic             ovf_reg;
  logic             we_reg;
  logic             halt_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] mac_acc;
  logic             mac_carry;

  horner_mac #(
    .WIDTH (WIDTH)
  ) u_mac (
    .acc      (acc_reg),
    .x        (x_reg),
    .coef     (coef_in),
    .acc_next (mac_acc),
    .carry    (mac_carry)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD:  state_next = ST_RUN;
      ST_RUN: begin
        if (remaining_reg == '0) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered status outputs. Status flags are decoded from
  // state_next so that they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg         <= '0;
      acc_reg       <= '0;
      d_reg         <= '0;
      remaining_reg <= '0;
      addr_reg      <= '0;
      ovf_reg       <= 1'b0;
      we_reg        <= 1'b0;
      halt_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      we_reg   <= (state_next == ST_WRITE);
      halt_reg <= (state_next == ST_HALT);
      busy_reg <= (state_next == ST_LOAD) || (state_next == ST_RUN);

      if (accept) begin
        x_reg         <= fraction;
        d_reg         <= degree;
        acc_reg       <= '0;
        ovf_reg       <= 1'b0;
        addr_reg      <= degree;
        remaining_reg <= degree;
      end

      if (state_reg == ST_LOAD) begin
        // The address runs one ahead of the coefficient being consumed.
        // For d=0 this wraps, but the fetched word is never used.
        addr_reg <= d_reg - DEG_W'(1);
      end

      if (state_reg == ST_RUN) begin
        acc_reg <= mac_acc;
        ovf_reg <= ovf_reg | mac_carry;
        if (remaining_reg != '0) begin
          remaining_reg <= remaining_reg - DEG_W'(1);
          addr_reg      <= addr_reg - DEG_W'(1);
        end
      end
    end
  end

  assign coef_addr = addr_reg;
  assign result    = acc_reg;
  assign we        = we_reg;
  assign halt      = halt_reg;
  assign busy      = busy_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_horner_eval_engine.sv
// Testbench for horner_eval_engine (WIDTH=8, DEG_W=6) with a 1-cycle
// coefficient store. Expected values come from a plain-arithmetic Horner
// model; HORNER_SAT_EN selects the saturating expectation.
module tb_horner_eval_engine;

  localparam int WIDTH = 8;
  localparam int DEG_W = 6;
  localparam int MOD   = 1 << WIDTH;
`ifdef HORNER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] fraction;
  logic [DEG_W-1:0] degree;
  logic [DEG_W-1:0] coef_addr;
  logic [WIDTH-1:0] coef_in;
  logic [WIDTH-1:0] result;
  logic             we;
  logic             halt;
  logic             busy;
  logic             ovf;

  logic [WIDTH-1:0] mem [0:63];

  int vectors    = 0;
  int miscompares = 0;

  int exp_acc [0:63];
  bit exp_ovf [0:63];

  always #5 clk = ~clk;

  // Coefficient store: synchronous read, exactly one cycle of latency.
  always @(posedge clk) coef_in <= mem[coef_addr];

  horner_eval_engine #(
    .WIDTH (WIDTH),
    .DEG_W (DEG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fraction  (fraction),
    .degree    (degree),
    .coef_addr (coef_addr),
    .coef_in   (coef_in),
    .result    (result),
    .we        (we),
    .halt      (halt),
    .busy      (busy),
    .ovf       (ovf)
  );

  task automatic check(input string name, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed=0x%0h expected=0x%0h", name, what, obs, exp);
    end
  endtask

  // Horner reference: acc starts at 0; for each coefficient from c[d] down
  // to c[0], acc = floor(acc*x/2^W) + c, with overflow past 2^W handled by
  // clamping or wrapping. exp_acc[k]/exp_ovf[k] hold the state after step k.
  function automatic void model(input int x, input int d);
    int acc;
    int s;
    bit ov;
    acc = 0;
    ov  = 1'b0;
    for (int k = 0; k <= d; k++) begin
      s = (acc * x) / MOD + int'(mem[d - k]);
      if (s >= MOD) begin
        ov  = 1'b1;
        acc = SAT ? MOD - 1 : s - MOD;
      end else begin
        acc = s;
      end
      exp_acc[k] = acc;
      exp_ovf[k] = ov;
    end
  endfunction

  // One evaluation, checked cycle by cycle from LOAD (cycle 1) to HALT
  // (cycle d+4). noisy: extra start pulses in cycles 1..4 with junk operands.
  // hold: leave start high so the next call is accepted straight from HALT.
  task automatic run_eval(input string name, input logic [WIDTH-1:0] x,
                          input int d, input bit noisy, input bit hold);
    int idx;
    model(int'(x), d);
    @(negedge clk);
    fraction = x;
    degree   = DEG_W'(d);
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= d + 4; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      check(name, $sformatf("busy@%0d", c), 32'(busy), 32'(c <= d + 2));
      check(name, $sformatf("we@%0d", c),   32'(we),   32'(c == d + 3));
      check(name, $sformatf("halt@%0d", c), 32'(halt), 32'(c == d + 4));
      if (c <= d + 1)
        check(name, $sformatf("coef_addr@%0d", c), 32'(coef_addr), 32'(d - c + 1));
      if (c <= 2) begin
        check(name, $sformatf("result@%0d", c), 32'(result), 32'd0);
        check(name, $sformatf("ovf@%0d", c),    32'(ovf),    32'd0);
      end else begin
        idx = (c - 3 > d) ? d : c - 3;
        check(name, $sformatf("result@%0d", c), 32'(result), 32'(exp_acc[idx]));
        check(name, $sformatf("ovf@%0d", c),    32'(ovf),    32'(exp_ovf[idx]));
      end
      if (!hold) begin
        if (noisy && c <= 4) begin
          start    = 1'b1;
          fraction = WIDTH'($urandom);
          degree   = DEG_W'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    $display("eval %s: x=0x%02h d=%0d result=0x%02h ovf=%0d (model 0x%02h/%0d)",
             name, x, d, result, ovf, exp_acc[d], exp_ovf[d]);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, "result",    32'(result),    32'd0);
    check(name, "coef_addr", 32'(coef_addr), 32'd0);
    check(name, "we",        32'(we),        32'd0);
    check(name, "halt",      32'(halt),      32'd0);
    check(name, "busy",      32'(busy),      32'd0);
    check(name, "ovf",       32'(ovf),       32'd0);
  endtask

  initial begin
    int rd;
    logic [WIDTH-1:0] rx;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst      = 1'b1;
    start    = 1'b0;
    fraction = '0;
    degree   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: degree zero returns c[0]
    mem[0] = 8'h37;
    run_eval("s1_d0", 8'h80, 0, 1'b0, 1'b0);
    check("s1_d0", "final", 32'(result), 32'h37);

    // 2: d=2 worked example
    mem[2] = 8'h40; mem[1] = 8'h20; mem[0] = 8'h10;
    run_eval("s2_d2", 8'h80, 2, 1'b0, 1'b0);
    check("s2_d2", "final", 32'(result), 32'h30);

    // 3: overflow
    mem[1] = 8'hFF; mem[0] = 8'hFF;
    run_eval("s3_ovf", 8'hFF, 1, 1'b0, 1'b0);
    check("s3_ovf", "final", 32'(result), SAT ? 32'hFF : 32'hFD);
    check("s3_ovf", "ovf",   32'(ovf),    32'd1);

    // 4: start pulses while busy are ignored
    mem[3] = 8'h11; mem[2] = 8'h22; mem[1] = 8'h33; mem[0] = 8'h44;
    run_eval("s4_noisy", 8'hC3, 3, 1'b1, 1'b0);

    // 5: reset mid-RUN, then a clean evaluation
    for (int i = 0; i <= 5; i++) mem[i] = 8'h55 + 8'(i);
    @(negedge clk);
    fraction = 8'h80;
    degree   = 6'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("s5_rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("s5_rst_held");
    @(negedge clk);
    rst = 1'b0;
    mem[2] = 8'h40; mem[1] = 8'h20; mem[0] = 8'h10;
    run_eval("s5_after_rst", 8'h80, 2, 1'b0, 1'b0);
    check("s5_after_rst", "final", 32'(result), 32'h30);
    check("s5_after_rst", "ovf",   32'(ovf),    32'd0);

    // 6: start held high, back-to-back every d+4 cycles, ovf cleared each time
    mem[1] = 8'hFF; mem[0] = 8'hFF;
    run_eval("s6_hold_a", 8'hFF, 1, 1'b0, 1'b1);
    mem[1] = 8'h01; mem[0] = 8'h02;
    run_eval("s6_hold_b", 8'h10, 1, 1'b0, 1'b1);
    mem[1] = 8'hFF; mem[0] = 8'hFF;
    run_eval("s6_hold_c", 8'hFF, 1, 1'b0, 1'b1);
    start = 1'b0;
    mem[1] = 8'h07; mem[0] = 8'h09;
    run_eval("s6_hold_d", 8'h40, 1, 1'b0, 1'b0);

    // Randomized evaluations
    for (int n = 0; n < 20; n++) begin
      rd = int'($urandom_range(0, 12));
      rx = WIDTH'($urandom);
      for (int i = 0; i <= rd; i++) mem[i] = WIDTH'($urandom);
      run_eval($sformatf("rand%0d", n), rx, rd, 1'b0, 1'b0);
    end

    // Maximum degree
    for (int i = 0; i < 64; i++) mem[i] = WIDTH'($urandom);
    run_eval("max_deg", 8'hE7, 63, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/horner_eval_engine.md
# horner_eval_engine

Parametrised polynomial evaluator: computes y = c[d]·x^d + … + c[1]·x + c[0] by Horner's rule. x is an unsigned pure fraction, and each coefficient is fetched from an external synchronous coefficient store over an address/data port. It succeeds the fixed 8-bit evaluator core and adds the following:
- Configurable data width and degree range.
- A start/busy handshake.
- Sticky overflow reporting.
- Optional saturation.

It sits between the chip I/O wrapper (fraction, degree, coefficient bus) and the result write-back path (we/halt).

## Interface
Parameters:
- WIDTH, 8: width of x, coefficients, accumulator and result. x is Q0.WIDTH.
- DEG_W, 6: width of degree and coefficient address. Maximum degree is 2**DEG_W−1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request evaluation; sampled only in IDLE/HALT
- fraction  in  WIDTH  x operand, latched when start is accepted
- degree  in  DEG_W  polynomial degree d, latched when start is accepted
- coef_addr  out  DEG_W  coefficient index being requested
- coef_in  in  WIDTH  coefficient data; valid exactly one cycle after coef_addr
- result  out  WIDTH  accumulator; final value is valid when we=1 and held afterwards
- we  out  1  one-cycle pulse: result is final
- halt  out  1  high in HALT (evaluation complete, idle)
- busy  out  1  high in LOAD and RUN
- ovf  out  1  sticky overflow for the current evaluation; cleared on accepted start

## Operation
States: IDLE, LOAD, RUN, WRITE, HALT (enum in the package).

IDLE/HALT:
- If start=1, latch fraction → x_q and degree → d_q.
- acc←0, ovf←0, coef_addr←degree, remaining←degree.
- Next state: LOAD.

LOAD:
- coef_addr=d_q is presented; the store returns c[d] next cycle.
- coef_addr←d_q−1 (wraps harmlessly when d_q=0; that value is never consumed).
- Next state: RUN.

RUN (one coefficient per cycle):
- acc←mac(acc, x_q, coef_in).
- If remaining=0 → WRITE. Otherwise remaining−1 and coef_addr−1.

WRITE:
- we=1 for this cycle; result=acc.
- Next state: HALT.

HALT:
- halt=1; result holds.
- Behaves as IDLE for start.

Arithmetic, mac(a, x, c):
- p = a·x, a 2·WIDTH-bit unsigned product.
- t = p[2W−1:W], truncation (floor).
- s = t + c, computed WIDTH+1 bits wide.
- If s[W]=1, set ovf. Result value depends on the configuration (see below).

Boundary behaviour:
- start while busy or in WRITE: ignored, no latch.
- d=0: exactly one RUN cycle; result=c[0].
- Reset at any time, including mid-RUN: state→IDLE immediately.
- Reset values: result=0, coef_addr=0, we=0, halt=0, busy=0, ovf=0.
- start held high across HALT: a new evaluation is accepted every time the block reaches HALT.

## Timing
- Accepting edge: cycle 0.
  - LOAD is cycle 1.
  - RUN covers cycles 2 … d+2.
  - WRITE (we=1) is cycle d+3.
  - halt rises in cycle d+4.
- Throughput: one evaluation per d+4 cycles with start held high.
- All outputs are registered; no combinational path from input to output.
- coef_in is sampled on the edge ending each RUN cycle. Store latency must be exactly 1 cycle.

## Configuration
- HORNER_SAT_EN defined:
  - On s[W]=1, acc←all ones (2**WIDTH−1).
  - Subsequent steps continue from the clamped value.
- Undefined:
  - acc←s[W−1:0] (modular wrap).
- ovf is reported identically in both builds.

## Structure
- horner_pkg holds:
  - the state enum state_t;
  - default WIDTH and DEG_W localparams;
  - the MAX_DEG helper.
- Sub-module horner_mac:
  - combinational multiply–truncate–add;
  - saturation under HORNER_SAT_EN;
  - outputs next accumulator and carry.
- Top level holds the FSM, counters and registers.

## Test plan
Coefficient store is a 1-cycle-latency model. WIDTH=8.

1. x=0x80, d=0, c0=0x37 → we in cycle 3, result=0x37, ovf=0, halt=1 from cycle 4.
2. x=0x80, d=2, c2=0x40, c1=0x20, c0=0x10 → acc sequence 0x40, 0x40, 0x30; we in cycle 5; result=0x30; coef_addr sequence 2, 1, 0.
3. x=0xFF, d=1, c1=0xFF, c0=0xFF → ovf=1. Result 0xFF with HORNER_SAT_EN, 0xFD without.
4. start pulsed in cycles 1–4 of a d=3 evaluation → ignored; single we in cycle 6; latched x and d unchanged.
5. rst asserted mid-RUN, then released; start with x=0x80, d=2 and the coefficients from scenario 2 → outputs zero during reset; clean evaluation gives 0x30 with ovf=0.
6. start held high, d=1 → we every 5 cycles; ovf cleared at each new start.
